mlp_seq_ctrl: RTL and testbench
===============================

Name: mlp_seq_ctrl

Overview:
- Top-level inference sequencer for the MLP datapath.
- On `start`, runs three engines in order: hidden layer (matmul+ReLU), output layer (matmul → z2), then argmax.
- Each engine uses a start-pulse/done-pulse handshake. The controller latches the argmax class and reports completion to the host.
- A per-stage watchdog flags an engine that never returns done.

Parameters:
- TIMEOUT_CYC, 4096, max cycles spent in any WAIT state before a timeout error.
- CNT_W, 13, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  host request to run one inference; sampled only in IDLE
- abort  in  1  host abort; returns to IDLE from any state
- clr_err  in  1  clears sticky error; leaves ERR
- busy  out  1  high in every state except IDLE and ERR
- done  out  1  one-cycle pulse when a result is latched
- result_index  out  4  class 0-9 of the last completed inference
- result_valid  out  1  high from the first done until the next accepted start, abort or reset
- error  out  1  sticky timeout flag
- err_stage  out  2  stage that timed out: 1=L1, 2=L2, 3=ARGMAX, 0=none
- l1_start  out  1  one-cycle start pulse to the hidden-layer engine
- l1_done  in  1  hidden-layer done pulse
- l2_start  out  1  one-cycle start pulse to the output-layer engine
- l2_done  in  1  output-layer done pulse
- am_start  out  1  one-cycle start pulse to argmax
- am_done  in  1  argmax done pulse
- am_index  in  4  argmax result; valid in the cycle `am_done` is high

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE
  - all outputs 0 (`busy`, `done`, `result_index`, `result_valid`, `error`, `err_stage`, all `*_start`)
  - watchdog counter=0
- States: IDLE, L1_GO, L1_WAIT, L2_GO, L2_WAIT, AM_GO, AM_WAIT, FIN, ERR.
- IDLE:
  - start=1 → L1_GO; clear `result_valid`.
  - start in any other state is ignored (no queueing).
- X_GO states: assert the matching `*_start` for exactly one cycle, clear the watchdog, move to X_WAIT next cycle.
- X_WAIT states:
  - Matching done=1 → next GO state (L1→L2_GO, L2→AM_GO, AM→FIN).
  - In AM_WAIT, also capture `am_index` into `result_index` on the same edge.
  - Done pulses from non-current engines are ignored.
  - A done pulse in the same cycle as its own start is not possible; an engine's done counts only in its WAIT state.
- Watchdog:
  - Increments every cycle in a WAIT state.
  - When the count reaches TIMEOUT_CYC-1 without the expected done: → ERR, error=1, err_stage=current stage.
  - A done arriving in that same cycle wins, and the stage completes normally.
- FIN: done=1 for one cycle, result_valid=1, → IDLE.
- Latency with zero-delay engines: minimum 7 cycles from start accepted to done; in general 7 + sum of engine wait cycles.
- ERR:
  - busy=0; start ignored; error and err_stage hold.
  - clr_err=1 → IDLE, error=0, err_stage=0.
- abort=1:
  - From any non-IDLE state → IDLE next cycle; no done; result_valid=0.
  - Any *_start pulse scheduled that cycle is suppressed.
  - abort has priority over done, timeout and clr_err in the same cycle.
  - In ERR, abort also clears error and err_stage.
- result_index holds its value until the next AM_WAIT capture or reset; it is not cleared by start.
- All outputs are registered.

Optional Feature:
- Macro: MLP_PERF_CNT_EN.
- Defined:
  - Adds output `perf_cycles` [31:0].
  - Counter clears on accepted start and increments each cycle while busy=1, saturating at 0xFFFFFFFF.
  - Value freezes at FIN, ERR or abort and holds until the next start; reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Engine model returns each done 3 cycles after its start, am_index=7; pulse start → l1/l2/am_start in order, done pulse 16 cycles after start, result_index=7, result_valid=1, busy low afterwards.
- start held high for 40 cycles → exactly one inference; a second run begins only after returning to IDLE with start still high.
- l2_done never asserted, TIMEOUT_CYC=16 → error=1, err_stage=2, busy=0, no am_start; clr_err → IDLE, error=0, and a new start runs normally.
- abort in AM_WAIT in the same cycle as am_done with am_index=4 → IDLE, no done, result_valid=0, result_index keeps its previous value.
- Spurious am_done during L1_WAIT plus rst_n pulsed low mid-L2_WAIT → spurious pulse ignored; reset forces all outputs 0 asynchronously and the next start sequences from L1.
- With MLP_PERF_CNT_EN and 3-cycle engines → perf_cycles=16 at done; it holds and then clears on the next start.

Source files
------------

// File: rtl/mlp_seq_ctrl.sv
// mlp_seq_ctrl: top-level inference sequencer for the MLP datapath.
// Runs the hidden-layer engine, the output-layer engine and argmax in order.
// Each engine uses a start/done pulse handshake and has its own watchdog.
// It latches the argmax class and reports completion to the host.
// Optional feature: define MLP_PERF_CNT_EN to add the perf_cycles busy-cycle
// counter output.
// All outputs are registered; each one is computed from the next state.
module mlp_seq_ctrl #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13   // needs 2**CNT_W > TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       clr_err,
  output logic       busy,
  output logic       done,
  output logic [3:0] result_index,
  output logic       result_valid,
  output logic       error,
  output logic [1:0] err_stage,
  output logic       l1_start,
  input  logic       l1_done,
  output logic       l2_start,
  input  logic       l2_done,
  output logic       am_start,
  input  logic       am_done,
  input  logic [3:0] am_index
`ifdef MLP_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_L1_GO,
    S_L1_WAIT,
    S_L2_GO,
    S_L2_WAIT,
    S_AM_GO,
    S_AM_WAIT,
    S_FIN,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wd_reg, wd_next;
  logic             error_reg, error_next;
  logic [1:0]       err_stage_reg, err_stage_next;
  logic             result_valid_reg, result_valid_next;
  logic [3:0]       result_index_reg, result_index_next;
  logic             busy_reg, done_reg;
  logic             l1_start_reg, l2_start_reg, am_start_reg;
  logic             busy_next;
  logic             wd_expired;
  logic             start_accept;

  // Watchdog expiry: the WAIT state has already spent TIMEOUT_CYC-1 cycles.
  assign wd_expired   = (wd_reg == WD_LAST);
  assign busy_next    = (state_next != S_IDLE) && (state_next != S_ERR);
  assign start_accept = (state_reg == S_IDLE) && (state_next == S_L1_GO);

  // Next-state, watchdog and result/error bookkeeping; abort overrides everything.
  always_comb begin
    state_next        = state_reg;
    wd_next           = wd_reg;
    error_next        = error_reg;
    err_stage_next    = err_stage_reg;
    result_valid_next = result_valid_reg;
    result_index_next = result_index_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next        = S_L1_GO;
          result_valid_next = 1'b0;
        end
      end
      S_L1_GO: begin
        wd_next    = '0;
        state_next = S_L1_WAIT;
      end
      S_L1_WAIT: begin
        // A done on the expiry cycle still completes the stage.
        if (l1_done) begin
          state_next = S_L2_GO;
        end else if (wd_expired) begin
          state_next     = S_ERR;
          error_next     = 1'b1;
          err_stage_next = 2'd1;
        end else begin
          wd_next = wd_reg + CNT_W'(1);
        end
      end
      S_L2_GO: begin
        wd_next    = '0;
        state_next = S_L2_WAIT;
      end
      S_L2_WAIT: begin
        if (l2_done) begin
          state_next = S_AM_GO;
        end else if (wd_expired) begin
          state_next     = S_ERR;
          error_next     = 1'b1;
          err_stage_next = 2'd2;
        end else begin
          wd_next = wd_reg + CNT_W'(1);
        end
      end
      S_AM_GO: begin
        wd_next    = '0;
        state_next = S_AM_WAIT;
      end
      S_AM_WAIT: begin
        if (am_done) begin
          state_next        = S_FIN;
          result_index_next = am_index;
          result_valid_next = 1'b1;
        end else if (wd_expired) begin
          state_next     = S_ERR;
          error_next     = 1'b1;
          err_stage_next = 2'd3;
        end else begin
          wd_next = wd_reg + CNT_W'(1);
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      S_ERR: begin
        if (clr_err) begin
          state_next     = S_IDLE;
          error_next     = 1'b0;
          err_stage_next = 2'd0;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // Abort beats done, timeout, clr_err and start, and keeps the old result.
    if (abort) begin
      state_next        = S_IDLE;
      wd_next           = '0;
      error_next        = 1'b0;
      err_stage_next    = 2'd0;
      result_valid_next = 1'b0;
      result_index_next = result_index_reg;
    end
  end

  // State, watchdog and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      wd_reg           <= '0;
      error_reg        <= 1'b0;
      err_stage_reg    <= 2'd0;
      result_valid_reg <= 1'b0;
      result_index_reg <= 4'd0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      l1_start_reg     <= 1'b0;
      l2_start_reg     <= 1'b0;
      am_start_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      wd_reg           <= wd_next;
      error_reg        <= error_next;
      err_stage_reg    <= err_stage_next;
      result_valid_reg <= result_valid_next;
      result_index_reg <= result_index_next;
      busy_reg         <= busy_next;
      done_reg         <= (state_next == S_FIN);
      l1_start_reg     <= (state_next == S_L1_GO);
      l2_start_reg     <= (state_next == S_L2_GO);
      am_start_reg     <= (state_next == S_AM_GO);
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign result_index = result_index_reg;
  assign result_valid = result_valid_reg;
  assign error        = error_reg;
  assign err_stage    = err_stage_reg;
  assign l1_start     = l1_start_reg;
  assign l2_start     = l2_start_reg;
  assign am_start     = am_start_reg;

`ifdef MLP_PERF_CNT_EN
  logic [31:0] perf_reg, perf_next;

  // Busy-cycle count including the current cycle; restarts on an accepted start,
  // saturates, and holds once busy drops (FIN exit, ERR, abort).
  always_comb begin
    perf_next = perf_reg;
    if (start_accept) begin
      perf_next = 32'd1;
    end else if (busy_next && (perf_reg != 32'hFFFF_FFFF)) begin
      perf_next = perf_reg + 32'd1;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reg <= 32'd0;
    end else begin
      perf_reg <= perf_next;
    end
  end

  assign perf_cycles = perf_reg;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// tb_mlp_seq_ctrl: table-driven and directed-sequence bench for mlp_seq_ctrl.
// A small engine model returns each done a fixed latency after its start pulse.
// Define MLP_PERF_CNT_EN to also check perf_cycles.
`timescale 1ns/1ps
module tb_mlp_seq_ctrl;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       clr_err = 1'b0;
  logic       busy, done, result_valid, error;
  logic [3:0] result_index;
  logic [1:0] err_stage;
  logic       l1_start, l2_start, am_start;
  logic       l1_done, l2_done, am_done;
  logic [3:0] am_index = 4'd0;
`ifdef MLP_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  // Engine-model and table-driven done sources are ORed onto the DUT inputs.
  logic m_l1_done = 1'b0, m_l2_done = 1'b0, m_am_done = 1'b0;
  logic t_l1_done = 1'b0, t_l2_done = 1'b0, t_am_done = 1'b0;
  assign l1_done = m_l1_done | t_l1_done;
  assign l2_done = m_l2_done | t_l2_done;
  assign am_done = m_am_done | t_am_done;

  int   lat_l1 = 3, lat_l2 = 3, lat_am = 3;
  logic en_l1 = 1'b0, en_l2 = 1'b0, en_am = 1'b0;
  int   cnt_l1 = 0, cnt_l2 = 0, cnt_am = 0;

  int n_vec = 0;
  int n_bad = 0;

  mlp_seq_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .clr_err(clr_err),
    .busy(busy), .done(done), .result_index(result_index),
    .result_valid(result_valid), .error(error), .err_stage(err_stage),
    .l1_start(l1_start), .l1_done(l1_done),
    .l2_start(l2_start), .l2_done(l2_done),
    .am_start(am_start), .am_done(am_done), .am_index(am_index)
`ifdef MLP_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial forever #5 clk = ~clk;

  // Engine model: a start seen in cycle c gives done in cycle c+1+latency.
  initial begin
    forever begin
      @(negedge clk);
      m_l1_done = 1'b0;
      m_l2_done = 1'b0;
      m_am_done = 1'b0;
      if (!rst_n) begin
        cnt_l1 = 0; cnt_l2 = 0; cnt_am = 0;
      end else begin
        if (cnt_l1 > 0) begin cnt_l1--; if (cnt_l1 == 0) m_l1_done = 1'b1; end
        if (cnt_l2 > 0) begin cnt_l2--; if (cnt_l2 == 0) m_l2_done = 1'b1; end
        if (cnt_am > 0) begin cnt_am--; if (cnt_am == 0) m_am_done = 1'b1; end
        if (l1_start && en_l1) cnt_l1 = lat_l1 + 1;
        if (l2_start && en_l2) cnt_l2 = lat_l2 + 1;
        if (am_start && en_am) cnt_am = lat_am + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000ns");
    $fatal(1);
  end

  typedef struct packed {
    logic        st, ab, cl, d1, d2, da;
    logic [3:0]  ai;
    logic [12:0] exp;  // {busy,done,l1s,l2s,ams,rv,ri[3:0],error,err_stage[1:0]}
  } vec_t;

  function automatic vec_t mk(input logic st, ab, cl, d1, d2, da, input logic [3:0] ai,
                              input logic bz, dn, s1, s2, sa, rv, input logic [3:0] ri);
    vec_t v;
    v.st = st; v.ab = ab; v.cl = cl; v.d1 = d1; v.d2 = d2; v.da = da; v.ai = ai;
    v.exp = {bz, dn, s1, s2, sa, rv, ri, 1'b0, 2'd0};
    return v;
  endfunction

  function automatic logic [12:0] status();
    return {busy, done, l1_start, l2_start, am_start, result_valid, result_index,
            error, err_stage};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_eng(input int a, input int b, input int c, input logic ea,
                         input logic eb, input logic ec);
    lat_l1 = a; lat_l2 = b; lat_am = c;
    en_l1 = ea; en_l2 = eb; en_am = ec;
  endtask

  // Pulse start at the current negedge (cycle 0) and record the cycle of each
  // start pulse and of done; -1 means it was not seen within max_cyc.
  task automatic run_track(input int max_cyc, output int c1, output int c2,
                           output int ca, output int cd);
    c1 = -1; c2 = -1; ca = -1; cd = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      if (l1_start && c1 < 0) c1 = k;
      if (l2_start && c2 < 0) c2 = k;
      if (am_start && ca < 0) ca = k;
      if (done) begin
        cd = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  vec_t tbl [16];

  initial begin
    int c1, c2, ca, cd, cnt, cnt_d, first_l1, second_l1, found, err_cyc, saw;

    //            st ab cl d1 d2 da ai   bz dn s1 s2 sa rv ri
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 5,  1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 9,  1, 1, 0, 0, 0, 1, 9);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 9);
    tbl[9]  = mk(0, 0, 0, 1, 1, 1, 3,  0, 0, 0, 0, 0, 1, 9);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 9);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 9);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 9);
    tbl[13] = mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 9);
    tbl[14] = mk(0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 9);
    tbl[15] = mk(0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 9);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(status()), 32'd0);
`ifdef MLP_PERF_CNT_EN
    check("reset_perf", perf_cycles, 32'd0);
`endif
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Cycle-by-cycle table with directly driven done inputs
    for (int i = 0; i < 16; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; clr_err = tbl[i].cl;
      t_l1_done = tbl[i].d1; t_l2_done = tbl[i].d2; t_am_done = tbl[i].da;
      am_index = tbl[i].ai;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(status()), 32'(tbl[i].exp));
      $display("vec%0d status=0x%04h", i, status());
    end
    start = 1'b0; abort = 1'b0; clr_err = 1'b0;
    t_l1_done = 1'b0; t_l2_done = 1'b0; t_am_done = 1'b0;
    @(negedge clk);

    // Zero-latency engines: minimum 7-cycle latency
    am_index = 4'd7;
    set_eng(0, 0, 0, 1'b1, 1'b1, 1'b1);
    run_track(40, c1, c2, ca, cd);
    $display("zero-lat run: l1=%0d l2=%0d am=%0d done=%0d", c1, c2, ca, cd);
    check("zl_l2_cycle", 32'(c2), 32'd3);
    check("zl_am_cycle", 32'(c3_fix(ca)), 32'd5);
    check("zl_done_cycle", 32'(cd), 32'd7);
`ifdef MLP_PERF_CNT_EN
    check("zl_perf", perf_cycles, 32'd7);
`endif
    @(negedge clk);

    // 3-cycle engines: done 16 cycles after start
    set_eng(3, 3, 3, 1'b1, 1'b1, 1'b1);
    run_track(60, c1, c2, ca, cd);
    $display("3-cycle run: l1=%0d l2=%0d am=%0d done=%0d", c1, c2, ca, cd);
    check("r3_l1_cycle", 32'(c1), 32'd1);
    check("r3_l2_cycle", 32'(c2), 32'd6);
    check("r3_am_cycle", 32'(ca), 32'd11);
    check("r3_done_cycle", 32'(cd), 32'd16);
    check("r3_result", {30'd0, result_valid, 1'b0} | 32'(result_index) << 4, 32'h72);
`ifdef MLP_PERF_CNT_EN
    check("r3_perf_done", perf_cycles, 32'd16);
`endif
    @(negedge clk);
    check("r3_after", {busy, done, result_valid, 1'b0, result_index}, 8'h27);
`ifdef MLP_PERF_CNT_EN
    check("r3_perf_hold", perf_cycles, 32'd16);
`endif

    // start held for 40 cycles: no queueing, restart only from IDLE
    start = 1'b1;
    cnt = 0; cnt_d = 0; first_l1 = -1; second_l1 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (l1_start) begin
        cnt++;
        if (first_l1 < 0) first_l1 = k;
        else if (second_l1 < 0) second_l1 = k;
      end
      if (done) cnt_d++;
`ifdef MLP_PERF_CNT_EN
      if (k == 18) check("held_perf_restart", perf_cycles, 32'd1);
`endif
    end
    start = 1'b0;
    $display("held start: l1 pulses=%0d first=%0d second=%0d dones=%0d",
             cnt, first_l1, second_l1, cnt_d);
    check("held_l1_first", 32'(first_l1), 32'd1);
    check("held_l1_second", 32'(second_l1), 32'd18);
    check("held_l1_count", 32'(cnt), 32'd3);
    check("held_done_count", 32'(cnt_d), 32'd2);
    found = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin found = 1; break; end
    end
    check("held_drain", 32'(found), 32'd1);
    check("held_result", 32'(result_index), 32'd7);

    // abort in AM_WAIT together with am_done
    am_index = 4'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (am_start) begin found = 1; break; end
      @(negedge clk);
    end
    check("abort_found_am_start", 32'(found), 32'd1);
    repeat (1 + lat_am) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("abort in AM_WAIT: status=0x%04h", status());
    check("abort_am_status", 32'(status()), {19'd0, 13'b0_0_000_0_0111_0_00});
    cnt_d = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) cnt_d++;
    end
    check("abort_am_quiet", 32'(cnt_d), 32'd0);

    // L2 never finishes: watchdog to ERR in stage 2
    am_index = 4'd7;
    set_eng(3, 3, 3, 1'b1, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    err_cyc = -1; saw = 0;
    for (int k = 1; k <= 100; k++) begin
      if (am_start) saw = 1;
      if (error) begin err_cyc = k; break; end
      @(negedge clk);
    end
    $display("l2 timeout: error at cycle %0d stage=%0d", err_cyc, err_stage);
    check("to2_cycle", 32'(err_cyc), 32'd23);
    check("to2_status", {busy, error, err_stage}, 32'b0110);
    check("to2_no_am_start", 32'(saw), 32'd0);
    start = 1'b1;
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (l1_start || busy) saw = 1;
    end
    start = 1'b0;
    check("err_start_ignored", {saw, error, err_stage}, 32'b0110);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_err_status", {busy, error, err_stage}, 32'd0);
    set_eng(3, 3, 3, 1'b1, 1'b1, 1'b1);
    run_track(60, c1, c2, ca, cd);
    check("after_clr_done_cycle", 32'(cd), 32'd16);
    check("after_clr_result", 32'(result_index), 32'd7);
    @(negedge clk);

    // Done on the watchdog expiry cycle wins
    set_eng(15, 0, 0, 1'b1, 1'b1, 1'b1);
    run_track(60, c1, c2, ca, cd);
    $display("l1 latency 15: done=%0d error=%0b", cd, error);
    check("wd_edge_done_cycle", 32'(cd), 32'd22);
    check("wd_edge_no_error", 32'(error), 32'd0);
    @(negedge clk);

    // One cycle later is a timeout in stage 1; abort in ERR clears it
    set_eng(16, 0, 0, 1'b1, 1'b1, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    err_cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      if (error) begin err_cyc = k; break; end
      @(negedge clk);
    end
    $display("l1 timeout: error at cycle %0d stage=%0d", err_cyc, err_stage);
    check("to1_cycle", 32'(err_cyc), 32'd18);
    check("to1_stage", 32'(err_stage), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_err_status", {busy, error, err_stage}, 32'd0);
    repeat (2) @(negedge clk);

    // Spurious am_done in L1_WAIT, then async reset in L2_WAIT
    set_eng(3, 3, 3, 1'b1, 1'b1, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c2 = -1; saw = 0;
    for (int k = 1; k <= 8; k++) begin
      if (l2_start && c2 < 0) c2 = k;
      if ((am_start || done) && c2 < 0) saw = 1;
      t_am_done = (k == 2);
      if (k < 8) @(negedge clk);
    end
    t_am_done = 1'b0;
    check("spur_l2_cycle", 32'(c2), 32'd6);
    check("spur_ignored", 32'(saw), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-cycle: status=0x%04h", status());
    check("async_reset_outputs", 32'(status()), 32'd0);
`ifdef MLP_PERF_CNT_EN
    check("async_reset_perf", perf_cycles, 32'd0);
`endif
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_track(60, c1, c2, ca, cd);
    $display("post-reset run: l1=%0d l2=%0d am=%0d done=%0d", c1, c2, ca, cd);
    check("post_reset_l1_cycle", 32'(c1), 32'd1);
    check("post_reset_l2_cycle", 32'(c2), 32'd6);
    check("post_reset_done_cycle", 32'(cd), 32'd16);
    check("post_reset_result", 32'(result_index), 32'd7);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  function automatic int c3_fix(input int v);
    return v;
  endfunction

endmodule
